// File: rtl/grey_pkg.sv
// grey_pkg: shared constants, Johnson digit codes and FSM states for the scan reader
package grey_pkg;
    localparam int DIGIT_W    = 5;
    localparam int NUM_DIGITS = 12;
    localparam int SEL_W      = 6;
    localparam logic [DIGIT_W-1:0] J0 = 5'b00000;
    localparam logic [DIGIT_W-1:0] J1 = 5'b00001;
    localparam logic [DIGIT_W-1:0] J2 = 5'b00011;
    localparam logic [DIGIT_W-1:0] J3 = 5'b00111;
    localparam logic [DIGIT_W-1:0] J4 = 5'b01111;
    localparam logic [DIGIT_W-1:0] J5 = 5'b11111;
    localparam logic [DIGIT_W-1:0] J6 = 5'b11110;
    localparam logic [DIGIT_W-1:0] J7 = 5'b11100;
    localparam logic [DIGIT_W-1:0] J8 = 5'b11000;
    localparam logic [DIGIT_W-1:0] J9 = 5'b10000;
    typedef enum logic [2:0] {
        S_IDLE, S_SETSEL, S_WAIT, S_CAPTURE, S_COMPARE, S_FINISH
    } state_t;
endpackage

// File: rtl/johnson_dec.sv
// johnson_dec: twisted-ring digit code to BCD, flagging the 22 unused codes
module johnson_dec
    import grey_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [3:0]         bcd,
    output logic               valid
);
    // one legal code per decade value, everything else is invalid
    always_comb begin
        bcd   = 4'd0;
        valid = 1'b1;
        case (code)
            J0: bcd = 4'd0;
            J1: bcd = 4'd1;
            J2: bcd = 4'd2;
            J3: bcd = 4'd3;
            J4: bcd = 4'd4;
            J5: bcd = 4'd5;
            J6: bcd = 4'd6;
            J7: bcd = 4'd7;
            J8: bcd = 4'd8;
            J9: bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/grey_scan_reader.sv
// grey_scan_reader: double-scans a multiplexed Johnson counter and reports a coherent BCD snapshot
module grey_scan_reader
    import grey_pkg::*;
#(
    parameter int DIGITS    = NUM_DIGITS,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [7:0]            CNT_OUT,
    output logic [SEL_W-1:0]      SEL,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  CODE_ERR,
    output logic                  STABLE_ERR,
    output logic [3:0]            ERR_DIGIT
);
    state_t              state, state_next;
    logic [SEL_W-1:0]    idx;
    logic                pass_b;
    logic [7:0]          retry;
    logic [7:0]          wait_cnt;
    logic [4*DIGITS-1:0] sh_a, sh_b;
    logic [3:0]          dig;
    logic                dig_ok;
    logic                unused_hi;

    assign unused_hi = ^CNT_OUT[7:5];

    johnson_dec u_dec (
        .code  (CNT_OUT[DIGIT_W-1:0]),
        .bcd   (dig),
        .valid (dig_ok)
    );

    assign BUSY = (state != S_IDLE) && (state != S_FINISH);
    assign DONE = (state == S_FINISH);

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_next;
    end

    // next-state logic: scan pass A, scan pass B, compare, retry or finish
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    state_next = START ? S_SETSEL : S_IDLE;
            S_SETSEL:  state_next = (SETTLE == 1) ? S_CAPTURE : S_WAIT;
            S_WAIT:    state_next = (wait_cnt == 8'(SETTLE - 2)) ? S_CAPTURE : S_WAIT;
            S_CAPTURE: state_next = !dig_ok ? S_FINISH :
                                    (idx < SEL_W'(DIGITS - 1) || !pass_b) ? S_SETSEL : S_COMPARE;
            S_COMPARE: state_next = (sh_a == sh_b || retry >= 8'(MAX_RETRY)) ? S_FINISH : S_SETSEL;
            S_FINISH:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // datapath: digit select, settle counter, shadow captures, result and error flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SEL        <= '0;
            BCD        <= '0;
            CODE_ERR   <= 1'b0;
            STABLE_ERR <= 1'b0;
            ERR_DIGIT  <= '0;
            idx        <= '0;
            pass_b     <= 1'b0;
            retry      <= '0;
            wait_cnt   <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
        end else begin
            case (state)
                S_IDLE: if (START) begin
                    CODE_ERR   <= 1'b0;
                    STABLE_ERR <= 1'b0;
                    ERR_DIGIT  <= '0;
                    idx        <= '0;
                    pass_b     <= 1'b0;
                    retry      <= '0;
                end
                S_SETSEL: begin
                    SEL      <= idx;
                    wait_cnt <= '0;
                end
                S_WAIT: wait_cnt <= wait_cnt + 8'd1;
                S_CAPTURE: if (!dig_ok) begin
                    CODE_ERR  <= 1'b1;
                    ERR_DIGIT <= idx[3:0];
                end else begin
                    for (int i = 0; i < DIGITS; i++)
                        if (idx == SEL_W'(i)) begin
                            if (pass_b) sh_b[4*i +: 4] <= dig;
                            else        sh_a[4*i +: 4] <= dig;
                        end
                    if (idx < SEL_W'(DIGITS - 1)) begin
                        idx <= idx + 1'b1;
                    end else if (!pass_b) begin
                        pass_b <= 1'b1;
                        idx    <= '0;
                    end
                end
                S_COMPARE: if (sh_a == sh_b) begin
                    BCD <= sh_a;
                end else if (retry < 8'(MAX_RETRY)) begin
                    retry  <= retry + 8'd1;
                    pass_b <= 1'b0;
                    idx    <= '0;
                end else begin
                    STABLE_ERR <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_grey_scan_reader.sv
// tb_grey_scan_reader: directed scoreboard bench for the scan reader against a modelled counter
module tb_grey_scan_reader;
    localparam logic [4:0] JT [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                       5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

    typedef struct {
        int          t;
        int          lat;
        logic [47:0] bcd;
        logic        ce;
        logic        se;
        logic [3:0]  ed;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  CNT_OUT;
    logic [5:0]  SEL;
    logic        BUSY, DONE, CODE_ERR, STABLE_ERR;
    logic [47:0] BCD;
    logic [3:0]  ERR_DIGIT;

    logic [47:0] cnt_bcd = '0;
    logic        bad_en = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    grey_scan_reader dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .CNT_OUT    (CNT_OUT),
        .SEL        (SEL),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .BCD        (BCD),
        .CODE_ERR   (CODE_ERR),
        .STABLE_ERR (STABLE_ERR),
        .ERR_DIGIT  (ERR_DIGIT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // counter model: selected digit as a Johnson code, junk in the ignored top bits
    always_comb begin
        logic [3:0] d;
        d = (SEL < 6'd12) ? 4'(cnt_bcd >> (4 * int'(SEL))) : 4'd0;
        CNT_OUT = {3'b101, (bad_en && SEL == 6'd5) ? 5'b01010 : JT[int'(d)]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every DONE pulse pops one expected result
    always @(negedge CLK) begin
        if (RST && DONE) begin
            exp_t e;
            check("done_pending", 64'(sb.size() > 0), 64'd1);
            check("busy_in_finish", 64'(BUSY), 64'd0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("latency", 64'(cyc - e.t - 1), 64'(e.lat));
                check("bcd", 64'(BCD), 64'(e.bcd));
                check("code_err", 64'(CODE_ERR), 64'(e.ce));
                check("stable_err", 64'(STABLE_ERR), 64'(e.se));
                check("err_digit", 64'(ERR_DIGIT), 64'(e.ed));
            end
        end
    end

    task automatic start_op(input bit push, input int lat, input logic [47:0] bcd,
                            input logic ce, input logic se, input logic [3:0] ed);
        exp_t e;
        START = 1'b1;
        if (push) begin
            e.t = cyc; e.lat = lat; e.bcd = bcd; e.ce = ce; e.se = se; e.ed = ed;
            sb.push_back(e);
        end
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", 64'(BUSY), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("done_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_cleared();
        check("rst_sel", 64'(SEL), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_bcd", 64'(BCD), 64'd0);
        check("rst_code_err", 64'(CODE_ERR), 64'd0);
        check("rst_stable_err", 64'(STABLE_ERR), 64'd0);
        check("rst_err_digit", 64'(ERR_DIGIT), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLK);
        check_cleared();
        RST = 1'b1;
        @(negedge CLK);

        cnt_bcd = 48'h123456789012;
        start_op(1, 73, 48'h123456789012, 0, 0, 0);
        wait_done(200);

        bad_en = 1'b1;
        start_op(1, 18, 48'h123456789012, 1, 0, 4'd5);
        wait_done(100);
        bad_en = 1'b0;

        cnt_bcd = 48'h000000000019;
        start_op(1, 146, 48'h000000000020, 0, 0, 0);
        repeat (40) @(negedge CLK);
        cnt_bcd = 48'h000000000020;
        wait_done(300);

        cnt_bcd = 48'h000000000020;
        start_op(1, 292, 48'h000000000020, 0, 1, 0);
        fork
            repeat (15) begin
                repeat (20) @(negedge CLK);
                cnt_bcd[3:0] = (cnt_bcd[3:0] == 4'd9) ? 4'd0 : cnt_bcd[3:0] + 4'd1;
            end
        join_none
        wait_done(400);
        repeat (10) @(negedge CLK);

        cnt_bcd = 48'h987654321098;
        start_op(0, 0, 0, 0, 0, 0);
        repeat (22) @(negedge CLK);
        check("sel_before_reset", 64'(SEL), 64'd7);
        RST = 1'b0;
        #1;
        check_cleared();
        @(negedge CLK);
        RST = 1'b1;
        repeat (100) @(negedge CLK);
        start_op(1, 73, 48'h987654321098, 0, 0, 0);
        wait_done(200);

        cnt_bcd = 48'h102030405060;
        start_op(1, 73, 48'h102030405060, 0, 0, 0);
        repeat (9) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (29) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(200);
        repeat (100) @(negedge CLK);
        check("idle_at_end", 64'(BUSY), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/grey_scan_reader.md
Name: grey_scan_reader

Overview:
- Reader side of the 12-digit Gray-decade counter's multiplexed output port.
- Drives the counter's 6-bit digit select, samples the 8-bit output byte, and decodes each 5-bit Johnson (twisted-ring) digit to BCD.
- Takes two consecutive full scans so it only reports a snapshot taken while the counter did not tick.
- Sits between the counter and any consumer needing a coherent 48-bit BCD value.

Parameters:
- DIGITS, 12, number of decade digits scanned (index 0 = ones … 11 = hundred-billions).
- SETTLE, 2, cycles between a SEL change and the capture of CNT_OUT (min 1).
- MAX_RETRY, 3, extra scan attempts after a pass mismatch before STABLE_ERR.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  request a snapshot; sampled only in IDLE.
- CNT_OUT  in  8  counter io_out; [4:0] = selected digit's Johnson code, [7:5] ignored.
- SEL  out  6  digit select to the counter (0..DIGITS-1).
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle completion pulse.
- BCD  out  4*DIGITS  last good snapshot, digit i at [4i+3:4i].
- CODE_ERR  out  1  invalid Johnson code seen in the last operation.
- STABLE_ERR  out  1  passes never matched within 1+MAX_RETRY attempts.
- ERR_DIGIT  out  4  digit index of the code error (0 when none).

Behaviour:
- Reset (RST=0, async): all outputs 0, FSM in IDLE, retry counter 0, shadow registers 0. Reset mid-operation abandons the scan; DONE is not pulsed.
- Johnson map, code→digit:
  - 00000→0, 00001→1, 00011→2, 00111→3, 01111→4
  - 11111→5, 11110→6, 11100→7, 11000→8, 10000→9
  - The other 22 codes are invalid.
- FSM states: IDLE, SETSEL, WAIT, CAPTURE, COMPARE, FINISH.
- IDLE:
  - START=1 → BUSY=1 next cycle.
  - CODE_ERR, STABLE_ERR, ERR_DIGIT clear.
  - Digit index = 0, pass = A, retry = 0; go to SETSEL.
- SETSEL: drive SEL = index (registered); go to WAIT.
- WAIT: count SETTLE-1 cycles, then CAPTURE. With SETTLE=1, go to CAPTURE directly.
- CAPTURE:
  - Decode CNT_OUT[4:0].
  - Invalid code → CODE_ERR=1, ERR_DIGIT=index, go to FINISH. BCD is not updated.
  - Pass A: write the decoded digit to shadow A.
  - Pass B: write the decoded digit to shadow B.
  - If index < DIGITS-1: index++ and go to SETSEL.
  - Otherwise, at the end of pass A: pass = B, index = 0, go to SETSEL.
  - Otherwise, at the end of pass B: go to COMPARE.
- Per-digit cost = SETTLE+1 cycles (SETSEL + WAIT + CAPTURE, with WAIT = SETTLE-1).
- COMPARE:
  - A==B → BCD ← A, go to FINISH.
  - A≠B and retry < MAX_RETRY → retry++, pass = A, index = 0, go to SETSEL.
  - A≠B otherwise → STABLE_ERR=1, go to FINISH. BCD is not updated.
- FINISH: DONE=1 for one cycle, BUSY=0 in the same cycle, go to IDLE. SEL holds its last value.
- Latency, clean first attempt: START sampled at cycle 0 → DONE high at cycle 2·DIGITS·(SETTLE+1)+1, which is 73 for the defaults. Each retry adds 2·DIGITS·(SETTLE+1)+1 cycles.
- Handshake:
  - START while BUSY is ignored, not queued.
  - START held high re-triggers on the cycle after FINISH.
- BCD changes only on a successful COMPARE. Error flags hold until the next accepted START.
- CNT_OUT is treated as synchronous to CLK; no synchroniser.

Decomposition:
- Package grey_pkg holds:
  - DIGIT_W=5, NUM_DIGITS=12, SEL_W=6.
  - The ten Johnson code constants.
  - The FSM state enum.
- Sub-module johnson_dec: combinational, 5-bit code in → 4-bit BCD plus valid out. Instantiated once, fed from CNT_OUT[4:0].

Test Plan:
- Static counter value 123456789012, START pulse at cycle 0 → SEL walks 0..11 twice; DONE at cycle 73; BCD=48'h123456789012; both error flags 0.
- Digit 5 presents code 01010 → CODE_ERR=1, ERR_DIGIT=5; DONE 1 cycle after the pass-A capture of digit 5; BCD keeps the prior value.
- Ones digit advances once, mid pass B, of the first attempt (…9 to …0 carry into tens) → one retry; DONE at cycle 146; BCD equals the post-tick value.
- Ones digit changes every 20 cycles → every COMPARE mismatches; STABLE_ERR=1 after 4 attempts; DONE at cycle 292; BCD unchanged.
- RST low for 1 cycle during WAIT of digit 7 → all outputs 0 immediately; no DONE; a later START completes normally in 73 cycles.
- START re-asserted at cycles 10 and 40 during BUSY → ignored; exactly one DONE, at cycle 73.
